game_round_ctrl: RTL
====================

# game_round_ctrl

Sequencing controller for the two-digit BCD seconds countdown. It loads the start time into the countdown digits and enables the one-second tick. It then waits for either a player answer or a countdown timeout, keeps round count and score, and stops the game after a fixed number of rounds. It sits between the player-input logic and the seconds countdown, and its status outputs drive the word selector and the display.

## Interface
Parameters:
- ROUNDS, 10, rounds per game (1–15)
- BONUS_SEC, 5, BCD seconds added on a correct answer (TIME_BONUS_EN only, 0–9)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a game from IDLE or DONE
- answer_valid  in  1  one-cycle pulse; player submitted an answer
- answer_correct  in  1  qualifies answer_valid
- time_sw1 / time_sw0  in  4 each  BCD start time, tens/ones (switches)
- time_remain1 / time_remain0  in  4 each  BCD time remaining from countdown
- timeout  in  1  countdown reached 00 (level)
- load_digit1 / load_digit0  out  4 each  BCD value presented to countdown load inputs
- time_reconfig1 / time_reconfig0  out  1 each  one-cycle load strobes, active-high
- sec_timer_enable  out  1  enables the one-second tick
- next_word  out  1  one-cycle pulse requesting a new prompt
- round_num  out  4  current round, binary, 1-based during play
- score  out  4  correct answers this game, binary
- game_over  out  1  high in DONE

## Operation
- States: IDLE, LOAD, RUN, NEXT, DONE.
- **IDLE:** all outputs 0. On `start`, clear score, set round_num = 1, pulse next_word, and go to LOAD.
- **LOAD (1 cycle):**
  - Drive load_digit1/0 with the load value and assert both reconfig strobes.
  - Go to RUN.
  - The load value is the switch value, with each digit >9 clamped to 9.
- **RUN:**
  - sec_timer_enable = 1.
  - `answer_valid`:
    - If answer_correct, increment score.
    - Go to NEXT in either case.
  - Else if `timeout`, go to NEXT with no score change.
  - Simultaneous answer_valid and timeout: the answer wins.
- **NEXT (1 cycle):**
  - sec_timer_enable = 0.
  - If round_num == ROUNDS, go to DONE.
  - Otherwise increment round_num, pulse next_word, and go to LOAD.
- **DONE:**
  - game_over = 1; score and round_num hold.
  - `start` restarts the game exactly as from IDLE.
- `start` is ignored in LOAD, RUN and NEXT.
- `answer_valid` is ignored outside RUN.
- Start time 00: the countdown raises timeout right after the load, and the round ends as a timeout.
- score never exceeds ROUNDS. No wrap is possible.

## Timing
- Reset values: state IDLE; every output 0, including load digits.
- `start` at cycle t produces:
  - next_word at t+1
  - strobes at t+1 (LOAD)
  - enable from t+2
- `answer_valid` at cycle t produces:
  - score update visible at t+1
  - enable low at t+1
  - next_word at t+2 and reload strobes at t+2, or game_over at t+2
- Timeout is sampled every RUN cycle. Latency to the reload strobe is 2 cycles.
- Reset mid-game returns to IDLE immediately. Score and round are lost.

## Configuration
- **TIME_BONUS_EN defined:**
  - After a correct answer, the next LOAD value is time_remain + BONUS_SEC, as a BCD add saturated at 99.
  - The remain value is captured in RUN on the answer cycle.
  - After a timeout or a wrong answer, the next LOAD uses the switches.
- **TIME_BONUS_EN undefined:** every LOAD uses the switches. BONUS_SEC is unused.

## Structure
- Shared package holds:
  - the state enum
  - the BCD digit type
  - the BCD clamp constant (9)
  - the saturation constant (99)
- One sub-module: `bcd_sat_add`, a combinational two-digit BCD adder with saturation at 99. It is instantiated only under TIME_BONUS_EN.

## Test plan
- Reset, then start with switches 3/0 → strobes at cycle +1 with digits 3/0, enable at +2, round_num = 1.
- ROUNDS = 3; three correct answers → score 3, game_over high 2 cycles after the third answer, enable low.
- Timeout in RUN with answer_valid in the same cycle (correct) → score increments and a single next_word pulse follows.
- Switches 12/15 → loaded digits 9/9. Switches 0/0 → the round ends by timeout with score unchanged.
- TIME_BONUS_EN, BONUS_SEC = 5: correct answer with remain 9/7 → next load 9/9; with remain 2/8 → next load 3/3.
- Assert rst low mid-RUN → all outputs 0 asynchronously. A later start begins at round 1 with score 0.

Source files
------------

// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the game round controller.
// The TIME_BONUS_EN build adds a reload bonus on correct answers.
package game_round_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       BCD_MAX = 4'd9;
  localparam logic [7:0] SAT_MAX = 8'h99;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/game_round_ctrl_bcd_sat_add.sv
// Two-digit BCD adder that saturates at 99.
// Used only when TIME_BONUS_EN is defined.
module bcd_sat_add
  import game_round_ctrl_pkg::*;
(
  input  bcd_t a1,
  input  bcd_t a0,
  input  bcd_t b1,
  input  bcd_t b0,
  output bcd_t s1,
  output bcd_t s0
);

  logic [4:0] ones;
  logic [4:0] tens;
  logic       carry;

  always_comb begin
    ones  = {1'b0, a0} + {1'b0, b0};
    carry = (ones > 5'd9);
    tens  = {1'b0, a1} + {1'b0, b1} + {4'd0, carry};
    s0    = carry ? 4'(ones - 5'd10) : ones[3:0];
    s1    = tens[3:0];
    if (tens > 5'd9) begin
      s1 = SAT_MAX[7:4];
      s0 = SAT_MAX[3:0];
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the BCD seconds countdown game.
// Define TIME_BONUS_EN to reload remain+BONUS_SEC after a correct answer.
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int ROUNDS    = 10,
  parameter int BONUS_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       answer_valid,
  input  logic       answer_correct,
  input  logic [3:0] time_sw1,
  input  logic [3:0] time_sw0,
  input  logic [3:0] time_remain1,
  input  logic [3:0] time_remain0,
  input  logic       timeout,
  output logic [3:0] load_digit1,
  output logic [3:0] load_digit0,
  output logic       time_reconfig1,
  output logic       time_reconfig0,
  output logic       sec_timer_enable,
  output logic       next_word,
  output logic [3:0] round_num,
  output logic [3:0] score,
  output logic       game_over
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] score_q, score_d;
  bcd_t       load1, load0;
  bcd_t       sw1_c, sw0_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    score_d = score_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d = '0;
          round_d = 4'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // answer has priority over a coincident timeout
        if (answer_valid) begin
          if (answer_correct) score_d = score_q + 4'd1;
          state_d = S_NEXT;
        end else if (timeout) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (round_q == LAST_ROUND) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sw1_c = bcd_clamp(time_sw1);
  assign sw0_c = bcd_clamp(time_sw0);

`ifdef TIME_BONUS_EN
  logic bonus_q, bonus_d;
  bcd_t rem1_q, rem1_d;
  bcd_t rem0_q, rem0_d;
  bcd_t sum1, sum0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bonus_q <= 1'b0;
      rem1_q  <= '0;
      rem0_q  <= '0;
    end else begin
      bonus_q <= bonus_d;
      rem1_q  <= rem1_d;
      rem0_q  <= rem0_d;
    end
  end

  always_comb begin
    bonus_d = bonus_q;
    rem1_d  = rem1_q;
    rem0_d  = rem0_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      bonus_d = 1'b0;
    end else if (state_q == S_RUN) begin
      if (answer_valid) begin
        bonus_d = answer_correct;
        rem1_d  = time_remain1;
        rem0_d  = time_remain0;
      end else if (timeout) begin
        bonus_d = 1'b0;
      end
    end
  end

  bcd_sat_add u_add (
    .a1 (rem1_q),
    .a0 (rem0_q),
    .b1 (4'd0),
    .b0 (4'(BONUS_SEC)),
    .s1 (sum1),
    .s0 (sum0)
  );

  assign load1 = bonus_q ? sum1 : sw1_c;
  assign load0 = bonus_q ? sum0 : sw0_c;
`else
  logic unused_remain;
  assign unused_remain = ^{time_remain1, time_remain0, 4'(BONUS_SEC)};

  assign load1 = sw1_c;
  assign load0 = sw0_c;
`endif

  // every LOAD entry doubles as the new-prompt request
  assign load_digit1      = (state_q == S_LOAD) ? load1 : '0;
  assign load_digit0      = (state_q == S_LOAD) ? load0 : '0;
  assign time_reconfig1   = (state_q == S_LOAD);
  assign time_reconfig0   = (state_q == S_LOAD);
  assign next_word        = (state_q == S_LOAD);
  assign sec_timer_enable = (state_q == S_RUN);
  assign game_over        = (state_q == S_DONE);
  assign round_num        = round_q;
  assign score            = score_q;

endmodule
